instr_loader: RTL and testbench

- Writer side of the 4-stage pipeline core's instruction memory: receives a framed byte stream, assembles 16-bit instruction words (opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0]), and writes them into the imem write port.
- Holds the core in reset while a program is loaded, and releases it only after a good checksum.
- Sits between the host/debug byte link and the core's instruction memory.

---
 rtl/instr_loader_if.sv | 26 ++
 rtl/instr_loader.sv | 146 ++++++++++++++
 tb/tb_instr_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and imem write/status bundle for the instruction loader.
// master = host/debug side, slave = loader side.
interface instr_loader_if #(
  parameter int ADDR_W = 2
) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              core_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, load_done, load_err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata, core_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/instr_loader.sv
// Framed byte-stream loader for the core's instruction memory; holds the core until a good checksum.
// Optional mid-frame idle timeout: define INSTR_LOADER_TIMEOUT_EN.
module instr_loader #(
  parameter int         ADDR_W      = 2,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           reset,
  instr_loader_if.slave  bus
);

  localparam int         CNT_W = ADDR_W + 1;
  localparam logic [8:0] DEPTH = 9'(1 << ADDR_W);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT, S_HI, S_LO, S_WR, S_CHK
  } state_t;

  state_t            state, next_state;
  logic              hs;
  logic              set_done, set_err;
  logic              n_bad;
  logic [CNT_W-1:0]  remaining;
  logic [7:0]        hi_byte;
  logic [7:0]        checksum;
  logic              in_ready_q, imem_we_q, core_hold_q, busy_q, load_done_q, load_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              timed_out;

  assign hs    = bus.in_valid && in_ready_q;
  assign n_bad = (bus.in_data == 8'h00) || ({1'b0, bus.in_data} > DEPTH);

`ifdef INSTR_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            waiting;

  // Only frame states that expect a byte count toward the idle limit.
  assign waiting   = (state == S_CNT) || (state == S_HI) || (state == S_LO) || (state == S_CHK);
  assign timed_out = waiting && !bus.in_valid && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       idle_cnt <= '0;
    else if (waiting && !bus.in_valid) idle_cnt <= idle_cnt + 1'b1;
    else                             idle_cnt <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: non-blocking assignment for every flop so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
  always_comb begin
    next_state = state;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: if (hs && bus.in_data == SYNC_BYTE) next_state = S_CNT;
      S_CNT: if (hs) begin
        if (n_bad) begin
          next_state = S_IDLE;
          set_err    = 1'b1;
        end else begin
          next_state = S_HI;
        end
      end
      S_HI:  if (hs) next_state = S_LO;
      S_LO:  if (hs) next_state = S_WR;
      S_WR:  next_state = (remaining == CNT_W'(1)) ? S_CHK : S_HI;
      S_CHK: if (hs) begin
        next_state = S_IDLE;
        if (bus.in_data == checksum) set_done = 1'b1;
        else                         set_err  = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
    if (timed_out) begin
      next_state = S_IDLE;
      set_err    = 1'b1;
      set_done   = 1'b0;
    end
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q  <= 1'b0;
      imem_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      core_hold_q <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      remaining   <= '0;
      hi_byte     <= '0;
      checksum    <= '0;
    end else begin
      in_ready_q  <= (next_state != S_WR);
      imem_we_q   <= (next_state == S_WR);
      busy_q      <= (next_state != S_IDLE);
      load_done_q <= set_done;
      load_err_q  <= set_err;
      if (set_done) core_hold_q <= 1'b0;
      case (state)
        S_IDLE: if (hs && bus.in_data == SYNC_BYTE) begin
          checksum    <= '0;
          addr_q      <= '0;
          core_hold_q <= 1'b1;
        end
        S_CNT: if (hs) remaining <= CNT_W'(bus.in_data);
        S_HI: if (hs) begin
          hi_byte  <= bus.in_data;
          checksum <= checksum ^ bus.in_data;
        end
        S_LO: if (hs) begin
          wdata_q  <= {hi_byte, bus.in_data};
          checksum <= checksum ^ bus.in_data;
        end
        S_WR: begin
          remaining <= remaining - 1'b1;
          // Last word stays at the top address instead of wrapping to zero.
          if (remaining != CNT_W'(1)) addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_hold  = core_hold_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = load_done_q;
  assign bus.load_err   = load_err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: good/bad frames, dropped bytes, bad counts, mid-frame reset, idle timeout.
module tb_instr_loader;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  int          wr_n = 0, done_n = 0, err_n = 0, rlow_n = 0, both_n = 0;
  logic [1:0]  wr_addr [0:63];
  logic [15:0] wr_data [0:63];
  int          b_wr, b_done, b_err, b_rlow;

  instr_loader_if #(.ADDR_W(2)) bus ();

  instr_loader #(.ADDR_W(2), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Event recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr[wr_n] = bus.imem_addr;
      wr_data[wr_n] = bus.imem_wdata;
      wr_n = wr_n + 1;
    end
    if (bus.load_done) done_n = done_n + 1;
    if (bus.load_err) err_n = err_n + 1;
    if (bus.load_done && bus.load_err) both_n = both_n + 1;
    if (!bus.in_ready && !reset) rlow_n = rlow_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = wr_n; b_done = done_n; b_err = err_n; b_rlow = rlow_n;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input int idx, input logic [1:0] a, input logic [15:0] d);
    check({tag, "_addr"}, 32'(wr_addr[idx]), 32'(a));
    check({tag, "_data"}, 32'(wr_data[idx]), 32'(d));
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_core_hold", 32'(bus.core_hold), 32'd1);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_we",        32'(bus.imem_we),   32'd0);
    check("rst_addr",      32'(bus.imem_addr), 32'd0);
    check("rst_wdata",     32'(bus.imem_wdata), 32'd0);
    check("rst_pulses",    32'({bus.load_done, bus.load_err}), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Good 4-word frame, back-to-back.
    snap();
    send_byte(8'hA5);
    check("f1_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h23);
    check("f1_we_latency", 32'(bus.imem_we), 32'd1);
    check("f1_we_data",    32'(bus.imem_wdata), 32'h1123);
    send_byte(8'h24); send_byte(8'h10);
    send_byte(8'h32); send_byte(8'h02);
    send_byte(8'h15); send_byte(8'h41);
    check("f1_hold_pre", 32'(bus.core_hold), 32'd1);
    send_byte(8'h62);
    check("f1_done_pulse", 32'(bus.load_done), 32'd1);
    check("f1_hold_drop",  32'(bus.core_hold), 32'd0);
    check("f1_busy_end",   32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("f1_nwr", 32'(wr_n - b_wr), 32'd4);
    check_write("f1_w0", b_wr + 0, 2'd0, 16'h1123);
    check_write("f1_w1", b_wr + 1, 2'd1, 16'h2410);
    check_write("f1_w2", b_wr + 2, 2'd2, 16'h3202);
    check_write("f1_w3", b_wr + 3, 2'd3, 16'h1541);
    check("f1_ndone", 32'(done_n - b_done), 32'd1);
    check("f1_nerr",  32'(err_n - b_err), 32'd0);
    check("f1_rlow",  32'(rlow_n - b_rlow), 32'd4);
    check("f1_hold_kept", 32'(bus.core_hold), 32'd0);

    // Same frame, wrong checksum.
    snap();
    send_byte(8'hA5);
    check("f2_hold_set", 32'(bus.core_hold), 32'd1);
    send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h23); send_byte(8'h24); send_byte(8'h10);
    send_byte(8'h32); send_byte(8'h02); send_byte(8'h15); send_byte(8'h41);
    send_byte(8'h63);
    check("f2_err_pulse", 32'(bus.load_err), 32'd1);
    check("f2_no_done",   32'(bus.load_done), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("f2_nwr",   32'(wr_n - b_wr), 32'd4);
    check_write("f2_w3", b_wr + 3, 2'd3, 16'h1541);
    check("f2_nerr",  32'(err_n - b_err), 32'd1);
    check("f2_ndone", 32'(done_n - b_done), 32'd0);
    check("f2_hold",  32'(bus.core_hold), 32'd1);

    // Junk bytes dropped, then a 1-word frame.
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    check("f3_idle_busy", 32'(bus.busy), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h30); send_byte(8'h22);
    send_byte(8'h12);
    repeat (3) @(posedge clk); #1;
    check("f3_nwr", 32'(wr_n - b_wr), 32'd1);
    check_write("f3_w0", b_wr, 2'd0, 16'h3022);
    check("f3_ndone", 32'(done_n - b_done), 32'd1);
    check("f3_hold",  32'(bus.core_hold), 32'd0);

    // Out-of-range counts.
    snap();
    send_byte(8'hA5); send_byte(8'h05);
    check("n5_err",  32'(bus.load_err), 32'd1);
    check("n5_busy", 32'(bus.busy), 32'd0);
    send_byte(8'hA5); send_byte(8'h00);
    check("n0_err",  32'(bus.load_err), 32'd1);
    check("n0_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check("nbad_nwr",  32'(wr_n - b_wr), 32'd0);
    check("nbad_nerr", 32'(err_n - b_err), 32'd2);
    check("nbad_hold", 32'(bus.core_hold), 32'd1);

    // Reset in the middle of the first write cycle.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h23);
    check("rw_we_before", 32'(bus.imem_we), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rw_we_drop",   32'(bus.imem_we), 32'd0);
    check("rw_in_ready",  32'(bus.in_ready), 32'd0);
    check("rw_busy",      32'(bus.busy), 32'd0);
    check("rw_addr",      32'(bus.imem_addr), 32'd0);
    check("rw_wdata",     32'(bus.imem_wdata), 32'd0);
    @(negedge clk) reset = 1'b0;
    snap();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h30); send_byte(8'h22);
    send_byte(8'h12);
    check("rw_done", 32'(bus.load_done), 32'd1);
    repeat (2) @(posedge clk); #1;
    check("rw_nwr", 32'(wr_n - b_wr), 32'd1);
    check_write("rw_w0", b_wr, 2'd0, 16'h3022);

    // Stall mid-frame with the host idle.
    snap();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
`ifdef INSTR_LOADER_TIMEOUT_EN
    repeat (7) @(posedge clk); #1;
    check("to_not_yet", 32'(bus.load_err), 32'd0);
    @(posedge clk); #1;
    check("to_err",  32'(bus.load_err), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    check("to_hold", 32'(bus.core_hold), 32'd1);
`else
    repeat (300) @(posedge clk); #1;
    check("stall_busy",  32'(bus.busy), 32'd1);
    check("stall_ready", 32'(bus.in_ready), 32'd1);
    check("stall_nerr",  32'(err_n - b_err), 32'd0);
    check("stall_hold",  32'(bus.core_hold), 32'd1);
`endif

    check("never_both", 32'(both_n), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
